// File: rtl/serial_link_pkg.sv
// Constants shared by the serial link transmitter and receiver: line levels,
// receiver FSM encoding and the default frame width.
package serial_link_pkg;

  localparam int DEFAULT_W = 8;

  localparam logic START_BIT = 1'b1;
  localparam logic IDLE_LVL  = 1'b0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/serial_frame_rx_if.sv
// Serial-line and parallel-word signals of the frame receiver. The driver side
// (serial source plus consumer) uses master; the receiver uses slave.
interface serial_frame_rx_if #(
  parameter int W = serial_link_pkg::DEFAULT_W
);
  // A word transfers on any rising edge where dvalid && rdy_i; dout is held
  // stable while dvalid=1, and dvalid never waits on rdy_i to assert.
  logic                    sdi;
  logic                    rdy_i;
  logic                    clr_ovr;
  logic [W-1:0]            dout;
  logic                    dvalid;
  logic                    busy;
  logic                    ovr;
  serial_link_pkg::state_t dbg_state;

  modport master (
    output sdi, rdy_i, clr_ovr,
    input  dout, dvalid, busy, ovr, dbg_state
  );

  modport slave (
    input  sdi, rdy_i, clr_ovr,
    output dout, dvalid, busy, ovr, dbg_state
  );
endinterface

// File: rtl/serial_frame_obuf.sv
// One-entry holding register between the deframer and the consumer; a frame
// completing while the held word is still unconsumed is dropped and flagged.
module serial_frame_obuf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] word_i,
  input  logic         rdy_i,
  input  logic         clr_ovr_i,
  output logic [W-1:0] dout_o,
  output logic         dvalid_o,
  output logic         ovr_o
);
  logic [W-1:0] dout_q, dout_d;
  logic         dvalid_q, dvalid_d;
  logic         ovr_q, ovr_d;
  logic         take;
  logic         overrun;

  assign take    = dvalid_q && rdy_i;
  assign overrun = load_i && dvalid_q && !rdy_i;

  // Overrun set has priority over the clear pulse so a drop is never lost.
  always_comb begin
    dout_d   = dout_q;
    dvalid_d = dvalid_q;
    ovr_d    = ovr_q;
    if (load_i && !overrun) begin
      dout_d   = word_i;
      dvalid_d = 1'b1;
    end else if (take) begin
      dvalid_d = 1'b0;
    end
    if (overrun) begin
      ovr_d = 1'b1;
    end else if (clr_ovr_i) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      ovr_q    <= ovr_d;
    end
  end

  assign dout_o   = dout_q;
  assign dvalid_o = dvalid_q;
  assign ovr_o    = ovr_q;
endmodule

// File: rtl/serial_frame_rx.sv
// Deframer for the one-bit-per-clock serial link: start bit '1', then W data
// bits MSB-first; completed words go to a valid/ready holding register.
module serial_frame_rx
  import serial_link_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic              clk,
  input  logic              rst,
  serial_frame_rx_if.slave  bus
);
  localparam int CNT_W = $clog2(W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(W - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  // Only W-1 bits need storing: the final data bit is taken straight from sdi.
  logic [W-2:0]     shreg_q;
  logic [W-1:0]     word_d;
  logic             load;

  assign word_d = {shreg_q, bus.sdi};
  assign load   = (state_q == ST_SHIFT) && (cnt_q == LAST_BIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.sdi == START_BIT) begin
            state_q <= ST_SHIFT;
            cnt_q   <= '0;
          end
        end
        ST_SHIFT: begin
          shreg_q <= word_d[W-2:0];
          if (cnt_q == LAST_BIT) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.busy      = (state_q == ST_SHIFT);
  assign bus.dbg_state = state_q;

  serial_frame_obuf #(.W(W)) u_obuf (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load),
    .word_i    (word_d),
    .rdy_i     (bus.rdy_i),
    .clr_ovr_i (bus.clr_ovr),
    .dout_o    (bus.dout),
    .dvalid_o  (bus.dvalid),
    .ovr_o     (bus.ovr)
  );
endmodule
